// File: rtl/nx_fifo_thr.sv
// nx_fifo_thr: show-ahead synchronous FIFO with arbitrary DEPTH, programmable
// almost-full/almost-empty thresholds and an optional high-water-mark monitor.
//
// Optional feature macro: NX_FIFO_THR_HWM_EN
//   defined   -> hwm tracks the peak occupancy since rst/clear
//   undefined -> no hwm register is built and hwm is tied to 0
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   wen, ren          write request, read/pop request
//   clear             synchronous flush of pointers/count/flags (array untouched)
//   wdata             write data
//   afull_thresh      almost-full level  (almost_full  = used >= level)
//   aempty_thresh     almost-empty level (almost_empty = used <= level)
//   rdata             head-of-queue data (combinational from the read pointer)
//   empty, full       occupancy flags
//   almost_full/empty threshold flags
//   used_slots        entries held
//   free_slots        DEPTH - used_slots
//   underflow         one-cycle pulse after a read request while empty
//   overflow          one-cycle pulse after a write request while full without a read
//   hwm               peak occupancy since rst/clear
module nx_fifo_thr #(
   parameter int unsigned DEPTH      = 6,
   parameter int unsigned WIDTH      = 263,
   parameter int unsigned DATA_RESET = 1,
   localparam int unsigned CW        = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wen,
   input  logic             ren,
   input  logic             clear,
   input  logic [WIDTH-1:0] wdata,
   input  logic [CW-1:0]    afull_thresh,
   input  logic [CW-1:0]    aempty_thresh,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             full,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [CW-1:0]    used_slots,
   output logic [CW-1:0]    free_slots,
   output logic             underflow,
   output logic             overflow,
   output logic [CW-1:0]    hwm
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wptr_q;
   logic [PW-1:0]    rptr_q;
   logic             wr_acc;
   logic             rd_acc;
   logic [CW-1:0]    used_next;
   logic [PW-1:0]    wptr_inc;
   logic [PW-1:0]    rptr_inc;

   // Pointers wrap at DEPTH-1 so non-power-of-two depths never alias.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Accept decisions and next occupancy; a full FIFO still takes a write when
   // a read frees a slot in the same cycle, an empty FIFO never bypasses.
   always_comb begin
      wr_acc    = wen && (!full || ren);
      rd_acc    = ren && !empty;
      used_next = used_slots + CW'(wr_acc) - CW'(rd_acc);
      wptr_inc  = ptr_inc(wptr_q);
      rptr_inc  = ptr_inc(rptr_q);
   end

   // Pointers, count, flags and error pulses.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wptr_q       <= '0;
         rptr_q       <= '0;
         used_slots   <= '0;
         free_slots   <= CW'(DEPTH);
         empty        <= 1'b1;
         full         <= 1'b0;
         almost_empty <= 1'b1;
         almost_full  <= (afull_thresh == '0);
         underflow    <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         if (wr_acc) wptr_q <= wptr_inc;
         if (rd_acc) rptr_q <= rptr_inc;
         used_slots   <= used_next;
         free_slots   <= CW'(DEPTH) - used_next;
         empty        <= (used_next == '0);
         full         <= (used_next == CW'(DEPTH));
         almost_full  <= (used_next >= afull_thresh);
         almost_empty <= (used_next <= aempty_thresh);
         underflow    <= ren && empty;
         overflow     <= wen && full && !ren;
      end
   end

   // Storage array; not reset, flush only moves pointers.
   always_ff @(posedge clk) begin
      if (!rst && !clear && wr_acc) mem[wptr_q] <= wdata;
   end

   // Show-ahead read port.
   generate
      if (DATA_RESET != 0) begin : g_rdata_zero
         assign rdata = empty ? '0 : mem[rptr_q];
      end else begin : g_rdata_raw
         assign rdata = mem[rptr_q];
      end
   endgenerate

`ifdef NX_FIFO_THR_HWM_EN
   // Peak occupancy; bounded by DEPTH because used_next never exceeds it.
   logic [CW-1:0] hwm_q;
   always_ff @(posedge clk) begin
      if (rst || clear) hwm_q <= '0;
      else if (used_next > hwm_q) hwm_q <= used_next;
   end
   assign hwm = hwm_q;
`else
   assign hwm = '0;
`endif

endmodule

// File: tb/tb_nx_fifo_thr.sv
// Self-checking bench for nx_fifo_thr (DEPTH=6, WIDTH=263, DATA_RESET=1).
// A queue holds the words expected at the head; tests compare rdata to it.
module tb_nx_fifo_thr;
   localparam int unsigned DEPTH = 6;
   localparam int unsigned WIDTH = 263;
   localparam int unsigned CW    = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst, wen, ren, clear;
   logic [WIDTH-1:0] wdata, rdata;
   logic [CW-1:0]    afull_thresh, aempty_thresh;
   logic             empty, full, almost_full, almost_empty, underflow, overflow;
   logic [CW-1:0]    used_slots, free_slots, hwm;

   int checks   = 0;
   int failures = 0;
   int m_used   = 0;
   logic [WIDTH-1:0] exp_q[$];

   nx_fifo_thr #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DATA_RESET(1)) dut (
      .clk(clk), .rst(rst), .wen(wen), .ren(ren), .clear(clear), .wdata(wdata),
      .afull_thresh(afull_thresh), .aempty_thresh(aempty_thresh), .rdata(rdata),
      .empty(empty), .full(full), .almost_full(almost_full), .almost_empty(almost_empty),
      .used_slots(used_slots), .free_slots(free_slots), .underflow(underflow),
      .overflow(overflow), .hwm(hwm));

   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] rnd();
      logic [287:0] t;
      t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
           $urandom(), $urandom(), $urandom(), $urandom()};
      return t[WIDTH-1:0];
   endfunction

   // Drive one cycle; scoreboard push on accepted write, pop on accepted read.
   task automatic tick(input logic w, input logic r, input logic [WIDTH-1:0] d,
                       input logic c, input logic rs);
      bit wacc, racc;
      wacc = w && ((m_used < DEPTH) || r);
      racc = r && (m_used > 0);
      wen = w; ren = r; wdata = d; clear = c; rst = rs;
      @(posedge clk);
      #1;
      if (rs || c) begin
         exp_q.delete();
         m_used = 0;
      end else begin
         if (racc) void'(exp_q.pop_front());
         if (wacc) exp_q.push_back(d);
         m_used = m_used + int'(wacc) - int'(racc);
      end
      wen = 1'b0; ren = 1'b0; clear = 1'b0; rst = 1'b0;
   endtask

   task automatic test_reset();
      tick(0, 0, '0, 0, 1);
      checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rst_empty got=%b exp=1", empty); end
      checks++; if (full !== 1'b0) begin failures++; $display("FAIL rst_full got=%b exp=0", full); end
      checks++; if (used_slots !== CW'(0)) begin failures++; $display("FAIL rst_used got=%0d exp=0", used_slots); end
      checks++; if (free_slots !== CW'(DEPTH)) begin failures++; $display("FAIL rst_free got=%0d exp=%0d", free_slots, DEPTH); end
      checks++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin failures++; $display("FAIL rst_thr got ae=%b af=%b exp ae=1 af=0", almost_empty, almost_full); end
      checks++; if (underflow !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL rst_err got u=%b o=%b exp 0 0", underflow, overflow); end
      checks++; if (hwm !== CW'(0)) begin failures++; $display("FAIL rst_hwm got=%0d exp=0", hwm); end
      checks++; if (rdata !== '0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
   endtask

   task automatic test_fill_drain();
      for (int i = 1; i <= DEPTH; i++) begin
         tick(1, 0, rnd(), 0, 0);
         checks++; if (used_slots !== CW'(i)) begin failures++; $display("FAIL fill_used got=%0d exp=%0d", used_slots, i); end
         checks++; if (almost_full !== (i >= 4)) begin failures++; $display("FAIL fill_afull w%0d got=%b exp=%b", i, almost_full, (i >= 4)); end
         checks++; if (almost_empty !== (i <= 1)) begin failures++; $display("FAIL fill_aempty w%0d got=%b exp=%b", i, almost_empty, (i <= 1)); end
         checks++; if (full !== (i == DEPTH)) begin failures++; $display("FAIL fill_full w%0d got=%b exp=%b", i, full, (i == DEPTH)); end
      end
      checks++; if (free_slots !== CW'(0)) begin failures++; $display("FAIL fill_free got=%0d exp=0", free_slots); end
      for (int i = 1; i <= DEPTH; i++) begin
         checks++; if (rdata !== exp_q[0]) begin failures++; $display("FAIL drain_data r%0d got=%h exp=%h", i, rdata, exp_q[0]); end
         tick(0, 1, '0, 0, 0);
      end
      checks++; if (empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", empty); end
      checks++; if (rdata !== '0) begin failures++; $display("FAIL drain_rdata0 got=%h exp=0", rdata); end
   endtask

   task automatic test_full_simul();
      for (int i = 0; i < DEPTH; i++) tick(1, 0, rnd(), 0, 0);
      for (int i = 0; i < 10; i++) begin
         checks++; if (rdata !== exp_q[0]) begin failures++; $display("FAIL fs_data c%0d got=%h exp=%h", i, rdata, exp_q[0]); end
         tick(1, 1, rnd(), 0, 0);
         checks++; if (used_slots !== CW'(DEPTH) || overflow !== 1'b0) begin failures++; $display("FAIL fs_used c%0d got used=%0d ovf=%b exp used=%0d ovf=0", i, used_slots, overflow, DEPTH); end
      end
   endtask

   task automatic test_overflow();
      logic [WIDTH-1:0] hd;
      hd = exp_q[0];
      tick(1, 0, rnd(), 0, 0);
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_pulse got=%b exp=1", overflow); end
      checks++; if (rdata !== hd || used_slots !== CW'(DEPTH)) begin failures++; $display("FAIL ovf_hold got used=%0d rdata=%h exp used=%0d rdata=%h", used_slots, rdata, DEPTH, hd); end
      tick(0, 0, '0, 0, 0);
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_one_cycle got=%b exp=0", overflow); end
      for (int i = 0; i < DEPTH; i++) begin
         checks++; if (rdata !== exp_q[0]) begin failures++; $display("FAIL ovf_drain r%0d got=%h exp=%h", i, rdata, exp_q[0]); end
         tick(0, 1, '0, 0, 0);
      end
      checks++; if (empty !== 1'b1) begin failures++; $display("FAIL ovf_empty got=%b exp=1", empty); end
   endtask

   task automatic test_empty_simul();
      logic [WIDTH-1:0] d;
      d = rnd();
      tick(1, 1, d, 0, 0);
      checks++; if (underflow !== 1'b1 || used_slots !== CW'(1)) begin failures++; $display("FAIL es_pulse got unf=%b used=%0d exp unf=1 used=1", underflow, used_slots); end
      checks++; if (rdata !== d) begin failures++; $display("FAIL es_data got=%h exp=%h", rdata, d); end
      tick(0, 0, '0, 0, 0);
      checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL es_one_cycle got=%b exp=0", underflow); end
      tick(0, 1, '0, 0, 0);
      checks++; if (empty !== 1'b1 || underflow !== 1'b0) begin failures++; $display("FAIL es_drain got empty=%b unf=%b exp 1 0", empty, underflow); end
   endtask

   task automatic test_thresh();
      for (int i = 0; i < 3; i++) tick(1, 0, rnd(), 0, 0);
      checks++; if (almost_full !== 1'b0) begin failures++; $display("FAIL thr_at3 got=%b exp=0", almost_full); end
      afull_thresh = CW'(3);
      tick(0, 0, '0, 0, 0);
      checks++; if (almost_full !== 1'b1) begin failures++; $display("FAIL thr_change got=%b exp=1", almost_full); end
      afull_thresh = CW'(7);
      for (int i = 0; i < 3; i++) tick(1, 0, rnd(), 0, 0);
      checks++; if (almost_full !== 1'b0 || full !== 1'b1) begin failures++; $display("FAIL thr_above_depth got af=%b full=%b exp af=0 full=1", almost_full, full); end
      afull_thresh = CW'(0);
      for (int i = 0; i < DEPTH; i++) tick(0, 1, '0, 0, 0);
      checks++; if (almost_full !== 1'b1 || empty !== 1'b1) begin failures++; $display("FAIL thr_zero got af=%b empty=%b exp af=1 empty=1", almost_full, empty); end
      afull_thresh = CW'(4);
      tick(0, 0, '0, 0, 0);
      checks++; if (almost_full !== 1'b0) begin failures++; $display("FAIL thr_restore got=%b exp=0", almost_full); end
   endtask

   task automatic test_clear_hwm();
      logic [WIDTH-1:0] d;
      logic [CW-1:0] exp_hwm;
      tick(0, 0, '0, 1, 0);
      for (int i = 0; i < 5; i++) tick(1, 0, rnd(), 0, 0);
`ifdef NX_FIFO_THR_HWM_EN
      exp_hwm = CW'(5);
`else
      exp_hwm = CW'(0);
`endif
      checks++; if (hwm !== exp_hwm || used_slots !== CW'(5)) begin failures++; $display("FAIL clr_hwm_before got hwm=%0d used=%0d exp hwm=%0d used=5", hwm, used_slots, exp_hwm); end
      tick(1, 0, rnd(), 1, 0);
      checks++; if (used_slots !== CW'(0) || empty !== 1'b1 || full !== 1'b0 || free_slots !== CW'(DEPTH)) begin failures++; $display("FAIL clr_state got used=%0d empty=%b full=%b free=%0d exp 0 1 0 %0d", used_slots, empty, full, free_slots, DEPTH); end
      checks++; if (almost_empty !== 1'b1 || almost_full !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin failures++; $display("FAIL clr_flags got ae=%b af=%b o=%b u=%b exp 1 0 0 0", almost_empty, almost_full, overflow, underflow); end
      checks++; if (hwm !== CW'(0)) begin failures++; $display("FAIL clr_hwm_after got=%0d exp=0", hwm); end
      d = rnd();
      tick(1, 0, d, 0, 0);
      checks++; if (rdata !== d || used_slots !== CW'(1)) begin failures++; $display("FAIL clr_first got used=%0d rdata=%h exp used=1 rdata=%h", used_slots, rdata, d); end
   endtask

   task automatic test_reset_mid();
      logic [WIDTH-1:0] d;
      for (int i = 0; i < 2; i++) tick(1, 0, rnd(), 0, 0);
      tick(1, 1, rnd(), 0, 1);
      checks++; if (empty !== 1'b1 || used_slots !== CW'(0)) begin failures++; $display("FAIL rmid_state got empty=%b used=%0d exp 1 0", empty, used_slots); end
      d = rnd();
      tick(1, 0, d, 0, 0);
      checks++; if (rdata !== d) begin failures++; $display("FAIL rmid_first got=%h exp=%h", rdata, d); end
      tick(0, 1, '0, 0, 0);
      checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rmid_drain got=%b exp=1", empty); end
   endtask

   initial begin
      rst = 1'b0; wen = 1'b0; ren = 1'b0; clear = 1'b0; wdata = '0;
      afull_thresh = CW'(4); aempty_thresh = CW'(1);
      test_reset();
      test_fill_drain();
      test_full_simul();
      test_overflow();
      test_empty_simul();
      test_thresh();
      test_clear_hwm();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
